// File: rtl/clk_fwd_pkg.sv
// Shared types and default sizing for the forwarded-clock transmitter.
package clk_fwd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

    localparam int DEF_HALF_W      = 8;
    localparam int DEF_BURST_W     = 16;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/OBUFDS.sv
// Behavioural stand-in for the vendor differential output buffer.
module OBUFDS #(
    parameter IOSTANDARD = "DEFAULT"
) (
    output logic O,
    output logic OB,
    input  logic I
);
    // The I/O standard only means something to the vendor implementation tools.
    if (IOSTANDARD == "") begin : g_no_iostd
    end

    assign O  = I;
    assign OB = ~I;
endmodule

// File: rtl/clk_fwd_sync.sv
// Async-reset flop chain bringing the run request into the clk domain.
module clk_fwd_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/clk_fwd_tx.sv
// Forwarded-clock transmitter: programmable half-period, burst or continuous,
// glitch-free start/stop, differential output through OBUFDS.
module clk_fwd_tx
    import clk_fwd_pkg::*;
#(
    parameter int HALF_W      = DEF_HALF_W,
    parameter int BURST_W     = DEF_BURST_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter     IOSTANDARD  = "DEFAULT"
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [HALF_W-1:0]  half_period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               busy,
    output logic               done,
    output logic               clk_out_se,
    output logic               clk_out_p,
    output logic               clk_out_n
);
    state_e               state_q, state_d;
    logic                 phase_q, phase_d;
    logic                 done_q, done_d;
    logic [HALF_W-1:0]    hcnt_q, hcnt_d;
    logic [HALF_W-1:0]    h_q, h_d;
    logic [BURST_W-1:0]   ccnt_q, ccnt_d;
    logic [BURST_W-1:0]   b_q, b_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                 en_s, en_s_d_q, en_s_d_d;
    logic                 rise, tick, last_fall;

    clk_fwd_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (en),
        .q     (en_s)
    );

    // en_s_d starts high and only follows en_s once the chain holds real
    // samples, so an en already high across reset never counts as a rise.
    always_comb begin
        fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
        en_s_d_d = fill_q[SYNC_STAGES-1] ? en_s : en_s_d_q;
    end

    assign rise      = en_s & ~en_s_d_q;
    assign tick      = (hcnt_q >= h_q - HALF_W'(1));
    assign last_fall = (b_q != '0) && (ccnt_q + BURST_W'(1) == b_q);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hcnt_d  = hcnt_q;
        ccnt_d  = ccnt_q;
        h_d     = h_q;
        b_d     = b_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d = 1'b0;
                if (rise) begin
                    h_d     = (half_period == '0) ? HALF_W'(1) : half_period;
                    b_d     = burst_len;
                    phase_d = 1'b1;
                    hcnt_d  = '0;
                    ccnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick && phase_q && last_fall) begin
                    phase_d = 1'b0;
                    hcnt_d  = '0;
                    ccnt_d  = ccnt_q + BURST_W'(1);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!en_s) begin
                    hcnt_d  = hcnt_q + HALF_W'(1);
                    state_d = STOP;
                end else if (tick) begin
                    phase_d = ~phase_q;
                    hcnt_d  = '0;
                    if (phase_q) ccnt_d = ccnt_q + BURST_W'(1);
                end else begin
                    hcnt_d = hcnt_q + HALF_W'(1);
                end
            end
            STOP: begin
                // A low phase is already a safe resting level; a high one runs to full width.
                if (!phase_q || tick) begin
                    phase_d = 1'b0;
                    hcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_q + HALF_W'(1);
                end
            end
            default: begin
                phase_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            done_q   <= 1'b0;
            hcnt_q   <= '0;
            ccnt_q   <= '0;
            h_q      <= '0;
            b_q      <= '0;
            fill_q   <= '0;
            en_s_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            done_q   <= done_d;
            hcnt_q   <= hcnt_d;
            ccnt_q   <= ccnt_d;
            h_q      <= h_d;
            b_q      <= b_d;
            fill_q   <= fill_d;
            en_s_d_q <= en_s_d_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign clk_out_se = phase_q;

    OBUFDS #(.IOSTANDARD(IOSTANDARD)) u_obufds (
        .O  (clk_out_p),
        .OB (clk_out_n),
        .I  (phase_q)
    );
endmodule

// File: tb/tb_clk_fwd_tx.sv
// Scoreboard bench for clk_fwd_tx: expected per-cycle waveforms are queued
// from a closed-form description of each scenario and popped as cycles run.
module tb_clk_fwd_tx;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  half_period;
    logic [15:0] burst_len;
    logic        busy, done, clk_out_se, clk_out_p, clk_out_n;

    typedef struct packed {
        logic se;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    clk_fwd_tx #(.HALF_W(8), .BURST_W(16), .SYNC_STAGES(SYNC), .IOSTANDARD("DEFAULT")) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .half_period (half_period),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .clk_out_se  (clk_out_se),
        .clk_out_p   (clk_out_p),
        .clk_out_n   (clk_out_n)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs j samples after en is raised, with en held for s samples.
    // Offset m=0 is the first high cycle; the burst ends on its B-th falling edge.
    function automatic exp_t model(input int j, input int h, input int b, input int s);
        exp_t r;
        int   m, e;
        bit   dn;
        r = '0;
        m = j - (SYNC + 1);
        if (m < 0) return r;
        if (b != 0 && (2 * b - 1) * h <= s) begin
            e  = (2 * b - 1) * h;
            dn = 1'b1;
        end else begin
            dn = 1'b0;
            if (((s / h) % 2) == 0) e = (s / h + 1) * h;
            else                    e = s + 1;
        end
        if (m < e) begin
            r.se   = ((m / h) % 2) == 0;
            r.busy = 1'b1;
        end else if (m == e) begin
            r.done = dn;
        end
        return r;
    endfunction

    task automatic run_scn(input string name, input int h_in, input int h_mid,
                           input int b, input int hi, input int tot);
        int   h_eff;
        exp_t e;
        h_eff       = (h_in == 0) ? 1 : h_in;
        half_period = 8'(h_in);
        burst_len   = 16'(b);
        en          = 1'b1;
        for (int j = 1; j <= tot; j++) sb.push_back(model(j, h_eff, b, hi));
        for (int j = 1; j <= tot; j++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({clk_out_se, busy, done} !== {e.se, e.busy, e.done}) begin
                bad++;
                $display("FAIL %s cyc=%0d se/busy/done got=%b%b%b want=%b%b%b",
                         name, j, clk_out_se, busy, done, e.se, e.busy, e.done);
            end
            total++;
            if ({clk_out_p, clk_out_n} !== {e.se, ~e.se}) begin
                bad++;
                $display("FAIL %s_pn cyc=%0d p/n got=%b%b want=%b%b",
                         name, j, clk_out_p, clk_out_n, e.se, ~e.se);
            end
            if (j == 4) half_period = 8'(h_mid);
            if (j == hi) en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; half_period = 8'd1; burst_len = 16'd0;
        repeat (3) step();
        total++;
        if ({clk_out_se, clk_out_p, clk_out_n, busy, done} !== 5'b00100) begin
            bad++;
            $display("FAIL reset se/p/n/busy/done got=%b want=00100",
                     {clk_out_se, clk_out_p, clk_out_n, busy, done});
        end
        rst_n = 1'b1;
        repeat (4) step();
        total++;
        if ({clk_out_se, clk_out_p, clk_out_n, busy, done} !== 5'b00100) begin
            bad++;
            $display("FAIL reset_idle se/p/n/busy/done got=%b want=00100",
                     {clk_out_se, clk_out_p, clk_out_n, busy, done});
        end
    endtask

    task automatic test_burst();
        run_scn("burst", 1, 1, 4, 10, 16);
    endtask

    task automatic test_clean_stop();
        run_scn("stop_hi", 3, 3, 0, 13, 22);
        run_scn("stop_lo", 3, 3, 0, 16, 24);
    endtask

    task automatic test_zero_half();
        run_scn("zero_half", 0, 0, 2, 8, 12);
    endtask

    task automatic test_mid_change();
        run_scn("mid_change", 2, 5, 0, 9, 16);
        run_scn("mid_next", 5, 5, 1, 8, 13);
    endtask

    task automatic test_done_vs_stop();
        run_scn("done_vs_stop", 2, 2, 2, 6, 12);
    endtask

    task automatic test_restart();
        run_scn("restart_hold", 1, 1, 1, 10, 13);
        run_scn("restart_new", 1, 1, 1, 4, 8);
    endtask

    task automatic test_async_reset();
        half_period = 8'd4; burst_len = 16'd0; en = 1'b1;
        repeat (4) step();
        total++;
        if (clk_out_se !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre se got=%b want=1", clk_out_se);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({clk_out_se, clk_out_p, clk_out_n, busy, done} !== 5'b00100) begin
            bad++;
            $display("FAIL areset_now se/p/n/busy/done got=%b want=00100",
                     {clk_out_se, clk_out_p, clk_out_n, busy, done});
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            total++;
            if ({clk_out_se, busy, done} !== 3'b000) begin
                bad++;
                $display("FAIL areset_hold cyc=%0d se/busy/done got=%b want=000",
                         j, {clk_out_se, busy, done});
            end
        end
        en = 1'b0;
        repeat (4) step();
        run_scn("areset_fresh", 1, 1, 2, 6, 10);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_clean_stop();
        test_zero_half();
        test_mid_change();
        test_done_vs_stop();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
